// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception controller: SR/Cause/EPC/PRId, exception entry, ERET and MFC0/MTC0.
// Optional Count/Compare timer on IP[15] when CP0_TIMER_EN is defined.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID      = 32'h2019_0305,
  parameter int unsigned EPC_ALIGN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_i,
  input  logic        bd_i,
  input  logic [4:0]  exc_code_i,
  input  logic [5:0]  hw_int_i,
  input  logic        we_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        eret_i,
  output logic        interrupt_o,
  output logic [31:0] epc_o,
  output logic        exl_o,
  output logic [31:0] rdata_o
);

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic [5:0]  ip_now;
  logic        int_req;
  logic        exc_req;
  logic [31:0] epc_victim;

  function automatic logic [31:0] align_epc(input logic [31:0] a);
    logic [31:0] r;
    r = a;
    if (EPC_ALIGN != 0) r[1:0] = 2'b00;
    return r;
  endfunction

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_pend_q, timer_pend_d;
  logic        timer_hit;

  // The match itself is visible in the Count==Compare cycle; the sticky bit holds it afterwards.
  assign timer_hit = (count_q == compare_q) && (compare_q != 32'd0);
  assign ip_now    = {hw_int_i[5] | timer_pend_q | timer_hit, hw_int_i[4:0]};
`else
  assign ip_now    = hw_int_i;
`endif

  assign int_req     = (|(ip_now & sr_im_q)) & sr_ie_q & ~sr_exl_q;
  assign exc_req     = (exc_code_i != 5'd0) & ~sr_exl_q;
  assign interrupt_o = int_req | exc_req;
  assign epc_victim  = bd_i ? (pc_i - 32'd4) : pc_i;
  assign epc_o       = epc_q;
  assign exl_o       = sr_exl_q;

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = ip_now;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (interrupt_o) begin
      // Exception entry swallows any MTC0 issued in the same cycle.
      sr_exl_d    = 1'b1;
      cause_bd_d  = bd_i;
      epc_d       = align_epc(epc_victim);
      cause_exc_d = int_req ? 5'd0 : exc_code_i;
    end else begin
      if (we_i) begin
        case (wr_addr_i)
          5'd12: begin
            sr_im_d  = wdata_i[15:10];
            sr_exl_d = wdata_i[1];
            sr_ie_d  = wdata_i[0];
          end
          5'd14:   epc_d = align_epc(wdata_i);
          default: ;
        endcase
      end
      if (eret_i) sr_exl_d = 1'b0;
    end
  end

`ifdef CP0_TIMER_EN
  always_comb begin
    count_d      = count_q + 32'd1;
    compare_d    = compare_q;
    timer_pend_d = timer_pend_q | timer_hit;
    if (!interrupt_o && we_i) begin
      if (wr_addr_i == 5'd9) count_d = wdata_i;
      if (wr_addr_i == 5'd11) begin
        compare_d    = wdata_i;
        timer_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q      <= 32'd0;
      compare_q    <= 32'd0;
      timer_pend_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      compare_q    <= compare_d;
      timer_pend_q <= timer_pend_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_im_q     <= 6'd0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    rdata_o = 32'd0;
    case (rd_addr_i)
      5'd12:   rdata_o = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
      5'd13:   rdata_o = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
      5'd14:   rdata_o = epc_q;
      5'd15:   rdata_o = PRID;
`ifdef CP0_TIMER_EN
      5'd9:    rdata_o = count_q;
      5'd11:   rdata_o = compare_q;
`endif
      default: rdata_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed, table-driven bench for cp0_exc_ctrl; timer sequence runs when CP0_TIMER_EN is defined.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_i;
  logic        bd_i;
  logic [4:0]  exc_code_i;
  logic [5:0]  hw_int_i;
  logic        we_i;
  logic [4:0]  wr_addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_addr_i;
  logic        eret_i;
  logic        interrupt_o;
  logic [31:0] epc_o;
  logic        exl_o;
  logic [31:0] rdata_o;

  int n_cmp  = 0;
  int n_fail = 0;

  cp0_exc_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc_i       (pc_i),
    .bd_i       (bd_i),
    .exc_code_i (exc_code_i),
    .hw_int_i   (hw_int_i),
    .we_i       (we_i),
    .wr_addr_i  (wr_addr_i),
    .wdata_i    (wdata_i),
    .rd_addr_i  (rd_addr_i),
    .eret_i     (eret_i),
    .interrupt_o(interrupt_o),
    .epc_o      (epc_o),
    .exl_o      (exl_o),
    .rdata_o    (rdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [5:0]  hw;
    logic [4:0]  exc;
    logic [31:0] pc;
    logic        bd;
    logic        eret;
    logic        e_irq;
    logic [31:0] e_epc;
    logic        e_exl;
    logic [31:0] e_rd;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic [4:0] ra,
                              logic [5:0] hw, logic [4:0] exc, logic [31:0] pc, logic bd,
                              logic eret, logic e_irq, logic [31:0] e_epc, logic e_exl,
                              logic [31:0] e_rd);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.hw = hw; v.exc = exc; v.pc = pc; v.bd = bd;
    v.eret = eret; v.e_irq = e_irq; v.e_epc = e_epc; v.e_exl = e_exl; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we_i = 1'b0; wr_addr_i = 5'd0; wdata_i = 32'd0; rd_addr_i = 5'd0; hw_int_i = 6'd0;
    exc_code_i = 5'd0; pc_i = 32'd0; bd_i = 1'b0; eret_i = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    idle();
    we_i = 1'b1; wr_addr_i = a; wdata_i = d;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    // we wa wd ra hw exc pc bd eret | irq epc exl rdata
    vecs[0]  = mk(0, 0, 0, 15, 0, 0, 0, 0, 0,               0, 0, 0, 32'h2019_0305);
    vecs[1]  = mk(1, 12, 32'h401, 12, 0, 0, 0, 0, 0,        0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 12, 6'h01, 0, 32'h3010, 0, 0,    1, 0, 0, 32'h401);
    vecs[3]  = mk(0, 0, 0, 13, 6'h01, 0, 0, 0, 0,           0, 32'h3010, 1, 32'h400);
    vecs[4]  = mk(0, 0, 0, 14, 0, 4, 0, 0, 0,               0, 32'h3010, 1, 32'h3010);
    vecs[5]  = mk(0, 0, 0, 12, 0, 0, 0, 0, 1,               0, 32'h3010, 1, 32'h403);
    vecs[6]  = mk(0, 0, 0, 13, 0, 12, 32'h3024, 1, 0,       1, 32'h3010, 0, 0);
    vecs[7]  = mk(0, 0, 0, 13, 0, 0, 0, 0, 0,               0, 32'h3020, 1, 32'h8000_0030);
    vecs[8]  = mk(0, 0, 0, 14, 0, 0, 0, 0, 1,               0, 32'h3020, 1, 32'h3020);
    vecs[9]  = mk(0, 0, 0, 12, 6'h01, 4, 32'h3100, 0, 0,    1, 32'h3020, 0, 32'h401);
    vecs[10] = mk(0, 0, 0, 13, 6'h01, 4, 0, 0, 0,           0, 32'h3100, 1, 32'h400);
    vecs[11] = mk(1, 14, 32'h3047, 14, 0, 0, 0, 0, 0,       0, 32'h3100, 1, 32'h3100);
    vecs[12] = mk(0, 0, 0, 14, 0, 0, 0, 0, 1,               0, 32'h3044, 1, 32'h3044);
    vecs[13] = mk(0, 0, 0, 12, 0, 0, 0, 0, 0,               0, 32'h3044, 0, 32'h401);
    vecs[14] = mk(1, 12, 32'h802, 12, 0, 0, 0, 0, 0,        0, 32'h3044, 0, 32'h401);
    vecs[15] = mk(1, 12, 32'hFC01, 12, 0, 0, 0, 0, 1,       0, 32'h3044, 1, 32'h802);
    vecs[16] = mk(0, 0, 0, 12, 0, 0, 0, 0, 0,               0, 32'h3044, 0, 32'hFC01);
    vecs[17] = mk(1, 14, 32'h1234_5678, 14, 0, 8, 32'h4000, 0, 0, 1, 32'h3044, 0, 32'h3044);
    vecs[18] = mk(0, 0, 0, 14, 0, 0, 0, 0, 0,               0, 32'h4000, 1, 32'h4000);
    vecs[19] = mk(1, 13, 32'hFFFF_FFFF, 13, 0, 0, 0, 0, 0,  0, 32'h4000, 1, 32'h20);
    vecs[20] = mk(0, 0, 0, 13, 0, 0, 0, 0, 0,               0, 32'h4000, 1, 32'h20);
    vecs[21] = mk(0, 0, 0, 3, 0, 0, 0, 0, 0,                0, 32'h4000, 1, 0);
    vecs[22] = mk(0, 0, 0, 13, 6'h20, 0, 0, 0, 0,           0, 32'h4000, 1, 32'h20);
    vecs[23] = mk(0, 0, 0, 13, 0, 0, 0, 0, 0,               0, 32'h4000, 1, 32'h8020);

    idle();
    reset_n = 1'b0;
    #1;
    check("reset irq", {31'd0, interrupt_o}, 32'd0);
    check("reset epc", epc_o, 32'd0);
    check("reset exl", {31'd0, exl_o}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      we_i = vecs[i].we; wr_addr_i = vecs[i].wa; wdata_i = vecs[i].wd; rd_addr_i = vecs[i].ra;
      hw_int_i = vecs[i].hw; exc_code_i = vecs[i].exc; pc_i = vecs[i].pc; bd_i = vecs[i].bd;
      eret_i = vecs[i].eret;
      #2;
      check($sformatf("v%0d irq", i), {31'd0, interrupt_o}, {31'd0, vecs[i].e_irq});
      check($sformatf("v%0d epc", i), epc_o, vecs[i].e_epc);
      check($sformatf("v%0d exl", i), {31'd0, exl_o}, {31'd0, vecs[i].e_exl});
      check($sformatf("v%0d rdata", i), rdata_o, vecs[i].e_rd);
    end

    // Asynchronous reset in the middle of a cycle with an interrupt pending.
    pulse_reset();
    mtc0(5'd12, 32'h0000_FC01);
    mtc0(5'd14, 32'h0000_0100);
    @(negedge clk);
    idle();
    rd_addr_i = 5'd12;
    hw_int_i  = 6'h3F;
    #1;
    check("pre-reset sr", rdata_o, 32'h0000_FC01);
    check("pre-reset irq", {31'd0, interrupt_o}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid reset sr", rdata_o, 32'd0);
    check("mid reset irq", {31'd0, interrupt_o}, 32'd0);
    check("mid reset epc", epc_o, 32'd0);
    rd_addr_i = 5'd13;
    #1;
    check("mid reset cause", rdata_o, 32'd0);
    rd_addr_i = 5'd14;
    #1;
    check("mid reset epc rd", rdata_o, 32'd0);
    hw_int_i = 6'd0;
    reset_n  = 1'b1;

`ifdef CP0_TIMER_EN
    begin
      int hit_at;
      pulse_reset();
      mtc0(5'd11, 32'd20);
      mtc0(5'd12, 32'h0000_8001);
      mtc0(5'd9, 32'd0);
      hit_at = -1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        idle();
        rd_addr_i = 5'd9;
        #2;
        if (interrupt_o) begin
          hit_at = k;
          break;
        end
      end
      check("timer hit cycle", hit_at, 20);
      check("timer count at hit", rdata_o, 32'd20);
      mtc0(5'd11, 32'd0);
      #2;
      check("timer masked by exl", {31'd0, interrupt_o}, 32'd0);
      @(negedge clk);
      idle();
      eret_i = 1'b1;
      @(negedge clk);
      idle();
      #2;
      check("timer exl cleared", {31'd0, exl_o}, 32'd0);
      check("timer pend cleared", {31'd0, interrupt_o}, 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
